// File: rtl/mux_rr_reg_if.sv
// Handshake and data bundle for mux_rr_reg.
// slave is the mux's view; master is the producer/consumer side.
interface mux_rr_reg_if #(
   parameter int N  = 12,
   parameter int DW = 32,
   parameter int NW = $clog2(N)
);
   logic [N-1:0]    in_valid;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [N-1:0]    out_sel;
   logic [NW-1:0]   out_idx;
   logic            out_ready;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel, out_idx
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel, out_idx
   );
endinterface

// File: rtl/mux_rr_reg.sv
// Registered N-channel mux with internal round-robin or fixed-priority
// arbitration. Valid/ready on every input and on the single output,
// which is a single register stage.
module mux_rr_reg #(
   parameter int N  = 12,
   parameter int DW = 32,
   parameter int RR = 1,
   parameter int NW = $clog2(N)
) (
   input logic         clk,
   input logic         nreset,
   mux_rr_reg_if.slave bus
);

   logic [NW-1:0] ptr;
   logic          out_valid_q;
   logic [DW-1:0] out_data_q;
   logic [N-1:0]  out_sel_q;
   logic [NW-1:0] out_idx_q;

   logic [N-1:0]  grant;
   logic [NW-1:0] gidx;
   logic [DW-1:0] gdata;
   logic          found;
   logic          load;
   logic          xfer;

   assign load = ~out_valid_q | bus.out_ready;
   assign xfer = found & load & nreset;

   // Search from the start point upward with wrap at N-1; first requester wins.
   always_comb begin
      int unsigned base;
      int unsigned idx;
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      base  = (RR != 0) ? 32'(ptr) : 32'd0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = base + k;
         if (idx >= N) idx = idx - N;
         if (!found && bus.in_valid[NW'(idx)]) begin
            grant[NW'(idx)] = 1'b1;
            gidx            = NW'(idx);
            found           = 1'b1;
         end
      end
   end

   // One-hot AND-OR selection of the granted channel's data.
   always_comb begin
      gdata = '0;
      for (int unsigned k = 0; k < N; k++) begin
         gdata = gdata | (bus.in_data[k*DW +: DW] & {DW{grant[k]}});
      end
   end

   // Output register and round-robin pointer.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_idx_q   <= '0;
         ptr         <= '0;
      end else if (xfer) begin
         out_valid_q <= 1'b1;
         out_data_q  <= gdata;
         out_sel_q   <= grant;
         out_idx_q   <= gidx;
         if (RR != 0) begin
            if (gidx == NW'(N - 1)) ptr <= '0;
            else                    ptr <= gidx + 1'b1;
         end
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready  = grant & {N{load & nreset}};
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;
   assign bus.out_idx   = out_idx_q;

endmodule
